// File: rtl/des_pkg.sv
// Shared DES key-schedule constants: PC-1/PC-2 tables (1-based DES bit numbers,
// DES bit 1 = MSB), per-round shift schedule, state type and rotate helpers.
package des_pkg;

    localparam int unsigned HALF_W = 28;
    localparam int unsigned RK_W   = 48;
    localparam int unsigned CD_W   = 56;

    typedef enum logic {IDLE = 1'b0, EMIT = 1'b1} state_t;

    localparam int unsigned PC1_TAB [CD_W] = '{
        57, 49, 41, 33, 25, 17,  9,
         1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27,
        19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,
         7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29,
        21, 13,  5, 28, 20, 12,  4
    };

    localparam int unsigned PC2_TAB [RK_W] = '{
        14, 17, 11, 24,  1,  5,
         3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8,
        16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55,
        30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53,
        46, 42, 50, 36, 29, 32
    };

    // Entry k-1 is the left-shift amount that produces round key Kk.
    localparam logic [1:0] SHIFT_TAB [16] = '{
        2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
        2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1
    };

    function automatic logic [CD_W-1:0] pc1(input logic [63:0] key);
        logic [CD_W-1:0] r;
        r = '0;
        for (int unsigned i = 0; i < CD_W; i++) begin
            r[6'(CD_W - 1 - i)] = key[6'(64 - PC1_TAB[i])];
        end
        return r;
    endfunction

    function automatic logic [HALF_W-1:0] rotl(input logic [HALF_W-1:0] x, input logic [1:0] n);
        return (n == 2'd1) ? {x[HALF_W-2:0], x[HALF_W-1]}
                           : {x[HALF_W-3:0], x[HALF_W-1:HALF_W-2]};
    endfunction

    function automatic logic [HALF_W-1:0] rotr(input logic [HALF_W-1:0] x, input logic [1:0] n);
        return (n == 2'd1) ? {x[0], x[HALF_W-1:1]}
                           : {x[1:0], x[HALF_W-1:2]};
    endfunction

endpackage

// File: rtl/des_pc2.sv
// Combinational DES PC-2 permutation: 56-bit {C,D} to 48-bit round key.
module des_pc2
    import des_pkg::*;
(
    input  logic [CD_W-1:0] cd,
    output logic [RK_W-1:0] rk
);

    always_comb begin
        rk = '0;
        for (int unsigned i = 0; i < RK_W; i++) begin
            rk[6'(RK_W - 1 - i)] = cd[6'(CD_W - PC2_TAB[i])];
        end
    end

endmodule

// File: rtl/des_key_sched_iter.sv
// Iterative DES key scheduler: one key in, 16 round keys out on a valid/ready stream.
// Optional key parity checking is enabled by defining DES_KEY_PARITY_CHK_EN.
module des_key_sched_iter
    import des_pkg::*;
#(
    parameter bit BACK2BACK = 1'b0
) (
    input  logic          CLK,
    input  logic          RST_N,
    input  logic          KEY_VALID,
    output logic          KEY_READY,
    input  logic [63:0]   KEY,
    input  logic          DECRYPT,
    output logic          RK_VALID,
    input  logic          RK_READY,
    output logic [RK_W-1:0] RK,
    output logic [3:0]    RK_IDX,
    output logic          RK_LAST,
    output logic          BUSY
`ifdef DES_KEY_PARITY_CHK_EN
    ,
    output logic          PARITY_ERR
`endif
);

    state_t            state_q, state_d;
    logic [HALF_W-1:0] c_q, c_d, d_q, d_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              mode_q, mode_d;
    logic              ready_en_q;
    logic              last, accept;
    logic [CD_W-1:0]   pc1_key;
    logic [RK_W-1:0]   pc2_out;

    des_pc2 u_pc2 (
        .cd (({c_q, d_q})),
        .rk (pc2_out)
    );

    always_comb begin
        state_d = state_q;
        c_d     = c_q;
        d_d     = d_q;
        cnt_d   = cnt_q;
        mode_d  = mode_q;
        pc1_key = pc1(KEY);
        last    = (cnt_q == 4'd15);

        KEY_READY = ((state_q == IDLE) && ready_en_q)
                 || (BACK2BACK && (state_q == EMIT) && last && RK_READY);
        accept    = KEY_VALID && KEY_READY;

        case (state_q)
            IDLE: ;
            EMIT: begin
                if (RK_READY) begin
                    if (!last) begin
                        cnt_d = cnt_q + 4'd1;
                        // Decrypt walks the encrypt rotations backwards: undo s(current key).
                        if (mode_q) begin
                            c_d = rotr(c_q, SHIFT_TAB[4'd15 - cnt_q]);
                            d_d = rotr(d_q, SHIFT_TAB[4'd15 - cnt_q]);
                        end else begin
                            c_d = rotl(c_q, SHIFT_TAB[cnt_q + 4'd1]);
                            d_d = rotl(d_q, SHIFT_TAB[cnt_q + 4'd1]);
                        end
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // A new key overrides the final-round exit when back-to-back accept is enabled.
        if (accept) begin
            state_d = EMIT;
            cnt_d   = '0;
            mode_d  = DECRYPT;
            if (DECRYPT) begin
                c_d = pc1_key[CD_W-1:HALF_W];
                d_d = pc1_key[HALF_W-1:0];
            end else begin
                c_d = rotl(pc1_key[CD_W-1:HALF_W], 2'd1);
                d_d = rotl(pc1_key[HALF_W-1:0], 2'd1);
            end
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q    <= IDLE;
            c_q        <= '0;
            d_q        <= '0;
            cnt_q      <= '0;
            mode_q     <= 1'b0;
            ready_en_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            c_q        <= c_d;
            d_q        <= d_d;
            cnt_q      <= cnt_d;
            mode_q     <= mode_d;
            ready_en_q <= 1'b1;
        end
    end

    assign RK_VALID = (state_q == EMIT);
    assign BUSY     = RK_VALID;
    assign RK       = RK_VALID ? pc2_out : '0;
    assign RK_IDX   = RK_VALID ? cnt_q : '0;
    assign RK_LAST  = RK_VALID && last;

`ifdef DES_KEY_PARITY_CHK_EN
    logic par_bad;
    assign par_bad = ~^KEY[63:56] | ~^KEY[55:48] | ~^KEY[47:40] | ~^KEY[39:32]
                   | ~^KEY[31:24] | ~^KEY[23:16] | ~^KEY[15:8]  | ~^KEY[7:0];

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            PARITY_ERR <= 1'b0;
        end else if (accept) begin
            PARITY_ERR <= par_bad;
        end
    end
`else
    logic unused_parity;
    assign unused_parity = ^{KEY[56], KEY[48], KEY[40], KEY[32],
                             KEY[24], KEY[16], KEY[8],  KEY[0]};
`endif

endmodule

// File: tb/tb_des_key_sched_iter.sv
// Self-checking bench for des_key_sched_iter (BACK2BACK=0 and BACK2BACK=1 instances).
// Define DES_KEY_PARITY_CHK_EN to also check PARITY_ERR.
module tb_des_key_sched_iter;

    logic        CLK = 1'b0;
    logic        RST_N = 1'b0;
    logic        KEY_VALID = 1'b0;
    logic [63:0] KEY = '0;
    logic        DECRYPT = 1'b0;
    logic        RK_READY = 1'b0;

    logic        key_ready0, key_ready1, rk_valid0, rk_valid1;
    logic [47:0] rk0, rk1;
    logic [3:0]  rk_idx0, rk_idx1;
    logic        rk_last0, rk_last1, busy0, busy1;
    bit          sel = 1'b0;

    logic        o_key_ready, o_rk_valid, o_rk_last, o_busy;
    logic [47:0] o_rk;
    logic [3:0]  o_rk_idx;

    assign o_key_ready = sel ? key_ready1 : key_ready0;
    assign o_rk_valid  = sel ? rk_valid1  : rk_valid0;
    assign o_rk        = sel ? rk1        : rk0;
    assign o_rk_idx    = sel ? rk_idx1    : rk_idx0;
    assign o_rk_last   = sel ? rk_last1   : rk_last0;
    assign o_busy      = sel ? busy1      : busy0;

`ifdef DES_KEY_PARITY_CHK_EN
    logic par0, par1, o_par;
    assign o_par = sel ? par1 : par0;
`endif

    des_key_sched_iter #(.BACK2BACK(1'b0)) dut0 (
        .CLK(CLK), .RST_N(RST_N), .KEY_VALID(KEY_VALID), .KEY_READY(key_ready0),
        .KEY(KEY), .DECRYPT(DECRYPT), .RK_VALID(rk_valid0), .RK_READY(RK_READY),
        .RK(rk0), .RK_IDX(rk_idx0), .RK_LAST(rk_last0), .BUSY(busy0)
`ifdef DES_KEY_PARITY_CHK_EN
        , .PARITY_ERR(par0)
`endif
    );

    des_key_sched_iter #(.BACK2BACK(1'b1)) dut1 (
        .CLK(CLK), .RST_N(RST_N), .KEY_VALID(KEY_VALID), .KEY_READY(key_ready1),
        .KEY(KEY), .DECRYPT(DECRYPT), .RK_VALID(rk_valid1), .RK_READY(RK_READY),
        .RK(rk1), .RK_IDX(rk_idx1), .RK_LAST(rk_last1), .BUSY(busy1)
`ifdef DES_KEY_PARITY_CHK_EN
        , .PARITY_ERR(par1)
`endif
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int failures = 0;

    localparam int M_PC1 [56] = '{
        57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
    };
    localparam int M_PC2 [48] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
    };
    localparam int M_SHIFT [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

    typedef struct {
        logic [47:0] rk;
        logic [3:0]  idx;
        logic        par;
    } exp_t;

    exp_t        sb[$];
    logic [63:0] pend_key[$];
    logic        pend_dec[$];
    int          accept_cyc[$];
    int          hs_count;
    int          first_hs_cyc;
    logic [47:0] first_rk, last_rk;

    function automatic logic [47:0] m_pc2(input logic [27:0] c, input logic [27:0] d);
        logic [55:0] cd;
        logic [47:0] r;
        cd = {c, d};
        r  = '0;
        for (int i = 0; i < 48; i++) r[6'(47 - i)] = cd[6'(56 - M_PC2[i])];
        return r;
    endfunction

    // Textbook schedule: C/D advanced by repeated single-bit left rotations.
    task automatic push_model(input logic [63:0] k, input logic dec);
        logic [55:0] p;
        logic [27:0] c, d;
        logic [47:0] ks [16];
        logic [7:0]  byt;
        logic        par;
        exp_t        e;
        p = '0;
        for (int i = 0; i < 56; i++) p[6'(55 - i)] = k[6'(64 - M_PC1[i])];
        c = p[55:28];
        d = p[27:0];
        for (int r = 0; r < 16; r++) begin
            for (int s = 0; s < M_SHIFT[r]; s++) begin
                c = {c[26:0], c[27]};
                d = {d[26:0], d[27]};
            end
            ks[r] = m_pc2(c, d);
        end
        par = 1'b0;
        for (int b = 0; b < 8; b++) begin
            byt = 8'(k >> (8 * b));
            if (^byt == 1'b0) par = 1'b1;
        end
        for (int i = 0; i < 16; i++) begin
            e.rk  = dec ? ks[15 - i] : ks[i];
            e.idx = 4'(i);
            e.par = par;
            sb.push_back(e);
        end
    endtask

    task automatic do_reset(input bit s);
        @(negedge CLK);
        RST_N = 1'b0;
        KEY_VALID = 1'b0;
        RK_READY = 1'b0;
        sel = s;
        sb.delete();
        pend_key.delete();
        pend_dec.delete();
        @(negedge CLK);
        RST_N = 1'b1;
    endtask

    // Presents queued keys (held until accepted) and checks every valid round key.
    task automatic run_stream(input string name, input bit rnd, input int stop_idx, input int budget);
        int cyc;
        bit stop;
        cyc = 0;
        stop = 1'b0;
        hs_count = 0;
        first_hs_cyc = -1;
        accept_cyc.delete();
        while (!stop && (pend_key.size() > 0 || sb.size() > 0) && cyc < budget) begin
            @(negedge CLK);
            if (pend_key.size() > 0) begin
                KEY = pend_key[0];
                DECRYPT = pend_dec[0];
                KEY_VALID = 1'b1;
            end else begin
                KEY = {$urandom, $urandom};
                DECRYPT = 1'($urandom);
                KEY_VALID = 1'b0;
            end
            RK_READY = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            #1;
            if (o_rk_valid) begin
                if (stop_idx >= 0 && int'(o_rk_idx) == stop_idx) begin
                    stop = 1'b1;
                end else if (sb.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL %s unexpected_rk_valid idx=%0d rk=%h", name, o_rk_idx, o_rk);
                end else begin
                    checks++;
                    if (o_rk !== sb[0].rk) begin
                        failures++;
                        $display("FAIL %s rk idx=%0d got=%h exp=%h", name, sb[0].idx, o_rk, sb[0].rk);
                    end
                    checks++;
                    if (o_rk_idx !== sb[0].idx) begin
                        failures++;
                        $display("FAIL %s rk_idx got=%0d exp=%0d", name, o_rk_idx, sb[0].idx);
                    end
                    checks++;
                    if (o_rk_last !== (sb[0].idx == 4'd15)) begin
                        failures++;
                        $display("FAIL %s rk_last idx=%0d got=%b", name, sb[0].idx, o_rk_last);
                    end
                    checks++;
                    if (o_busy !== 1'b1) begin
                        failures++;
                        $display("FAIL %s busy got=%b exp=1", name, o_busy);
                    end
`ifdef DES_KEY_PARITY_CHK_EN
                    checks++;
                    if (o_par !== sb[0].par) begin
                        failures++;
                        $display("FAIL %s parity_err got=%b exp=%b", name, o_par, sb[0].par);
                    end
`endif
                    if (RK_READY) begin
                        if (hs_count == 0) begin
                            first_hs_cyc = cyc;
                            first_rk = o_rk;
                        end
                        last_rk = o_rk;
                        hs_count++;
                        void'(sb.pop_front());
                    end
                end
            end
            if (!stop && KEY_VALID && o_key_ready) begin
                push_model(pend_key[0], pend_dec[0]);
                accept_cyc.push_back(cyc);
                void'(pend_key.pop_front());
                void'(pend_dec.pop_front());
            end
            cyc++;
        end
        KEY_VALID = 1'b0;
        checks++;
        if (cyc >= budget) begin
            failures++;
            $display("FAIL %s timeout after %0d cycles, %0d keys left", name, cyc, sb.size());
        end
    endtask

    task automatic test_reset;
        sel = 1'b0;
        RST_N = 1'b0;
        #1;
        checks++;
        if ({o_key_ready, o_rk_valid, o_rk_last, o_busy} !== 4'b0000) begin
            failures++;
            $display("FAIL reset flags {key_ready,rk_valid,rk_last,busy} got=%b exp=0000",
                     {o_key_ready, o_rk_valid, o_rk_last, o_busy});
        end
        checks++;
        if (o_rk !== 48'h0 || o_rk_idx !== 4'h0) begin
            failures++;
            $display("FAIL reset rk/idx got=%h/%0d exp=0/0", o_rk, o_rk_idx);
        end
`ifdef DES_KEY_PARITY_CHK_EN
        checks++;
        if (o_par !== 1'b0) begin
            failures++;
            $display("FAIL reset parity_err got=%b exp=0", o_par);
        end
`endif
        @(negedge CLK);
        RST_N = 1'b1;
        #1;
        checks++;
        if (o_key_ready !== 1'b0) begin
            failures++;
            $display("FAIL reset key_ready_before_clock got=%b exp=0", o_key_ready);
        end
        @(negedge CLK);
        checks++;
        if (o_key_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset key_ready_after_release got=%b exp=1", o_key_ready);
        end
    endtask

    task automatic test_single(input string name, input logic dec,
                               input logic [47:0] exp_first, input logic [47:0] exp_last);
        do_reset(1'b0);
        pend_key.push_back(64'h133457799BBCDFF1);
        pend_dec.push_back(dec);
        run_stream(name, 1'b0, -1, 100);
        checks++;
        if (hs_count != 16) begin
            failures++;
            $display("FAIL %s handshakes got=%0d exp=16", name, hs_count);
        end
        checks++;
        if (first_rk !== exp_first) begin
            failures++;
            $display("FAIL %s first_rk got=%h exp=%h", name, first_rk, exp_first);
        end
        checks++;
        if (last_rk !== exp_last) begin
            failures++;
            $display("FAIL %s last_rk got=%h exp=%h", name, last_rk, exp_last);
        end
        checks++;
        if (accept_cyc.size() != 1 || first_hs_cyc != accept_cyc[0] + 1) begin
            failures++;
            $display("FAIL %s first_rk_latency got_cycle=%0d accepts=%0d", name, first_hs_cyc, accept_cyc.size());
        end
        @(negedge CLK);
        #1;
        checks++;
        if (o_key_ready !== 1'b1 || o_rk_valid !== 1'b0 || o_busy !== 1'b0) begin
            failures++;
            $display("FAIL %s after_session {key_ready,rk_valid,busy} got=%b exp=100",
                     name, {o_key_ready, o_rk_valid, o_busy});
        end
    endtask

    task automatic test_stall;
        do_reset(1'b0);
        for (int i = 0; i < 3; i++) begin
            pend_key.push_back({$urandom, $urandom});
            pend_dec.push_back(1'($urandom));
        end
        run_stream("stall", 1'b1, -1, 600);
        checks++;
        if (hs_count != 48) begin
            failures++;
            $display("FAIL stall handshakes got=%0d exp=48", hs_count);
        end
    endtask

    task automatic test_mid_reset;
        do_reset(1'b0);
        pend_key.push_back(64'hA5A5_1234_5678_9ABC);
        pend_dec.push_back(1'b0);
        run_stream("mid_reset_pre", 1'b0, 7, 40);
        RST_N = 1'b0;
        #1;
        checks++;
        if (o_rk_valid !== 1'b0 || o_busy !== 1'b0 || o_key_ready !== 1'b0) begin
            failures++;
            $display("FAIL mid_reset async {rk_valid,busy,key_ready} got=%b exp=000",
                     {o_rk_valid, o_busy, o_key_ready});
        end
        sb.delete();
        @(negedge CLK);
        RST_N = 1'b1;
        @(negedge CLK);
        #1;
        checks++;
        if (o_rk_valid !== 1'b0) begin
            failures++;
            $display("FAIL mid_reset stale_rk_valid got=%b exp=0", o_rk_valid);
        end
        pend_key.push_back(64'h0123456789ABCDEF);
        pend_dec.push_back(1'b0);
        run_stream("mid_reset_post", 1'b0, -1, 100);
        checks++;
        if (hs_count != 16) begin
            failures++;
            $display("FAIL mid_reset_post handshakes got=%0d exp=16", hs_count);
        end
    endtask

    task automatic test_back_to_back(input bit s);
        int exp_gap;
        exp_gap = s ? 16 : 17;
        do_reset(s);
        pend_key.push_back(64'h133457799BBCDFF1);
        pend_dec.push_back(1'b0);
        pend_key.push_back(64'h0123456789ABCDEF);
        pend_dec.push_back(1'b1);
        run_stream(s ? "b2b_on" : "b2b_off", 1'b0, -1, 120);
        checks++;
        if (hs_count != 32) begin
            failures++;
            $display("FAIL b2b(%0d) handshakes got=%0d exp=32", s, hs_count);
        end
        checks++;
        if (accept_cyc.size() != 2) begin
            failures++;
            $display("FAIL b2b(%0d) accepts got=%0d exp=2", s, accept_cyc.size());
        end else if (accept_cyc[1] - accept_cyc[0] != exp_gap) begin
            failures++;
            $display("FAIL b2b(%0d) key_spacing got=%0d exp=%0d", s, accept_cyc[1] - accept_cyc[0], exp_gap);
        end
    endtask

`ifdef DES_KEY_PARITY_CHK_EN
    task automatic test_parity;
        do_reset(1'b0);
        pend_key.push_back(64'h133457799BBCDFF0);
        pend_dec.push_back(1'b0);
        pend_key.push_back(64'h133457799BBCDFF1);
        pend_dec.push_back(1'b0);
        run_stream("parity", 1'b0, -1, 120);
        checks++;
        if (o_par !== 1'b0) begin
            failures++;
            $display("FAIL parity final got=%b exp=0", o_par);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_single("encrypt", 1'b0, 48'h1B02EFFC7072, 48'hCB3D8B0E17F5);
        test_single("decrypt", 1'b1, 48'hCB3D8B0E17F5, 48'h1B02EFFC7072);
        test_stall();
        test_mid_reset();
        test_back_to_back(1'b0);
        test_back_to_back(1'b1);
`ifdef DES_KEY_PARITY_CHK_EN
        test_parity();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
